// File: rtl/eq_pkg.sv
// Shared types and constants for the channel sequencer: state encoding,
// sample width and the engine channel-select codes.
package eq_pkg;
    localparam int SMPL_W = 24;

    localparam logic CHNL_LFT  = 1'b0;
    localparam logic CHNL_RGHT = 1'b1;

    typedef logic signed [SMPL_W-1:0] smpl_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LFT  = 2'd1,
        ST_RGHT = 2'd2,
        ST_DONE = 2'd3
    } state_t;
endpackage

// File: rtl/chnl_seq_if.sv
// Bundle of the sequencer's I2S input, filter-engine handshake and output pair.
// The sequencer connects through the master modport, its environment through slave.
interface chnl_seq_if;
    import eq_pkg::*;

    logic  vld;
    smpl_t lft_chnnl;
    smpl_t rght_chnnl;
    logic  eng_strt;
    logic  eng_chnl;
    smpl_t eng_smpl;
    logic  eng_done;
    smpl_t eng_rslt;
    logic  out_vld;
    smpl_t out_lft;
    smpl_t out_rght;
    logic  ovrn;
    logic  tmo;

    modport master (
        input  vld, lft_chnnl, rght_chnnl, eng_done, eng_rslt,
        output eng_strt, eng_chnl, eng_smpl, out_vld, out_lft, out_rght, ovrn, tmo
    );

    modport slave (
        output vld, lft_chnnl, rght_chnnl, eng_done, eng_rslt,
        input  eng_strt, eng_chnl, eng_smpl, out_vld, out_lft, out_rght, ovrn, tmo
    );
endinterface

// File: rtl/eng_wdog.sv
// Engine-response watchdog: counts enabled cycles since the last clear and
// flags expiry once the count reaches TMO_CYC.
module eng_wdog #(
    parameter int TMO_CYC = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int              CNT_W = $clog2(TMO_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TMO_CYC);

    logic [CNT_W-1:0] cnt;

    // Holds at the limit so a stalled FSM can never wrap back to a short count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = en && (cnt == LIMIT);
endmodule

// File: rtl/chnl_seq.sv
// Sequences left/right I2S samples through one shared filter engine with a
// one-deep input buffer and an engine timeout. Optional CHNL_SEQ_OVRN_CNT_EN adds ovrn_cnt.
module chnl_seq
    import eq_pkg::*;
#(
    parameter int TMO_CYC = 1023
) (
    input  logic          clk,
    input  logic          rst_n,
    chnl_seq_if.master    bus
`ifdef CHNL_SEQ_OVRN_CNT_EN
    ,
    output logic [7:0]    ovrn_cnt
`endif
);
    state_t state, state_nxt;

    logic  pend;
    smpl_t hold_l, hold_r;
    smpl_t work_l, work_r;
    smpl_t res_l, res_r;

    logic  consume, capture;
    logic  launch, adv, tmo_c, busy, expired;
    smpl_t rslt_c;

    logic  eng_strt_q, eng_chnl_q, out_vld_q, ovrn_q;
    smpl_t eng_smpl_q, out_lft_q, out_rght_q;

    // A new pair may land in the same cycle the FSM empties the buffer.
    assign consume = (state == ST_IDLE) && pend;
    assign capture = bus.vld && (!pend || consume);
    assign busy    = (state == ST_LFT) || (state == ST_RGHT);

    eng_wdog #(.TMO_CYC(TMO_CYC)) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (launch),
        .en      (busy),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        adv       = 1'b0;
        tmo_c     = 1'b0;
        rslt_c    = (state == ST_LFT) ? work_l : work_r;
        if (busy) begin
            if (bus.eng_done) begin
                adv    = 1'b1;
                rslt_c = bus.eng_rslt;
            end else if (expired) begin
                adv   = 1'b1;
                tmo_c = 1'b1;
            end
        end
        case (state)
            ST_IDLE: begin
                if (pend) begin
                    state_nxt = ST_LFT;
                    launch    = 1'b1;
                end
            end
            ST_LFT: begin
                if (adv) begin
                    state_nxt = ST_RGHT;
                    launch    = 1'b1;
                end
            end
            ST_RGHT: begin
                if (adv) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
        end else if (capture) begin
            pend <= 1'b1;
        end else if (consume) begin
            pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            hold_l <= bus.lft_chnnl;
            hold_r <= bus.rght_chnnl;
        end
        if (consume) begin
            work_l <= hold_l;
            work_r <= hold_r;
        end
        if (adv && (state == ST_LFT)) begin
            res_l <= rslt_c;
        end
        if (adv && (state == ST_RGHT)) begin
            res_r <= rslt_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_strt_q <= 1'b0;
            eng_chnl_q <= CHNL_LFT;
            eng_smpl_q <= '0;
            out_vld_q  <= 1'b0;
            out_lft_q  <= '0;
            out_rght_q <= '0;
            ovrn_q     <= 1'b0;
        end else begin
            eng_strt_q <= launch;
            out_vld_q  <= (state == ST_DONE);
            ovrn_q     <= bus.vld && pend && !consume;
            if (launch) begin
                if (state == ST_IDLE) begin
                    eng_chnl_q <= CHNL_LFT;
                    eng_smpl_q <= hold_l;
                end else begin
                    eng_chnl_q <= CHNL_RGHT;
                    eng_smpl_q <= work_r;
                end
            end
            if (state == ST_DONE) begin
                out_lft_q  <= res_l;
                out_rght_q <= res_r;
            end
        end
    end

`ifdef CHNL_SEQ_OVRN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovrn_cnt <= '0;
        end else if (ovrn_q && (ovrn_cnt != 8'hFF)) begin
            ovrn_cnt <= ovrn_cnt + 8'd1;
        end
    end
`endif

    assign bus.eng_strt = eng_strt_q;
    assign bus.eng_chnl = eng_chnl_q;
    assign bus.eng_smpl = eng_smpl_q;
    assign bus.out_vld  = out_vld_q;
    assign bus.out_lft  = out_lft_q;
    assign bus.out_rght = out_rght_q;
    assign bus.ovrn     = ovrn_q;
    assign bus.tmo      = tmo_c;
endmodule

// File: tb/tb_chnl_seq.sv
// Self-checking bench for chnl_seq: vector table plus hand-written corner
// sequences, with a behavioural filter engine and an output scoreboard.
module tb_chnl_seq;
    import eq_pkg::*;

    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    chnl_seq_if bus();
`ifdef CHNL_SEQ_OVRN_CNT_EN
    logic [7:0] ovrn_cnt;
`endif

    chnl_seq #(.TMO_CYC(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef CHNL_SEQ_OVRN_CNT_EN
        ,
        .ovrn_cnt (ovrn_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
    } pair_t;
    pair_t sb[$];

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        int          dly;
        bit          silent;
        logic [23:0] el;
        logic [23:0] er;
        int          ntmo;
    } vec_t;
    vec_t vt[6];

    // engine model controls and observed events
    int   eng_dly = 5;
    bit   eng_silent = 1'b0;
    bit   stray_req = 1'b0;
    bit   sb_on = 1'b1;
    int   strt_cyc = 0;
    int   adv_cyc = 0;
    int   tmo_seen = 0;
    int   ovrn_seen = 0;
    int   ovrn_cyc = 0;
    logic exp_chnl = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Filter engine: answers eng_strt with eng_smpl+1 after eng_dly cycles unless silent.
    initial begin
        int          ecnt;
        logic [23:0] arg;
        ecnt = -1;
        arg = '0;
        bus.eng_done = 1'b0;
        bus.eng_rslt = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.eng_done = 1'b0;
            if (!rst_n) begin
                ecnt = -1;
                exp_chnl = 1'b0;
            end else begin
                if (bus.eng_strt) begin
                    chk("eng_chnl", {31'd0, bus.eng_chnl}, {31'd0, exp_chnl});
                    exp_chnl = ~exp_chnl;
                    arg = bus.eng_smpl;
                    strt_cyc = cyc;
                    ecnt = eng_silent ? -1 : eng_dly;
                end else if (ecnt > 0) begin
                    ecnt--;
                end
                if (ecnt == 0) begin
                    chk("eng_smpl_stable", {8'd0, bus.eng_smpl}, {8'd0, arg});
                    bus.eng_done = 1'b1;
                    bus.eng_rslt = arg + 24'd1;
                    ecnt = -1;
                end else if (stray_req) begin
                    bus.eng_done = 1'b1;
                    bus.eng_rslt = 24'h5A5A5A;
                    stray_req = 1'b0;
                end
            end
        end
    end

    // Output monitor and scoreboard, sampled on the falling edge.
    initial begin
        pair_t p;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.eng_done || bus.tmo) adv_cyc = cyc;
                if (bus.tmo) begin
                    tmo_seen++;
                    chk("tmo_delay", cyc - strt_cyc, TMO);
                end
                if (bus.ovrn) begin
                    ovrn_seen++;
                    ovrn_cyc = cyc;
                end
                if (bus.out_vld && sb_on) begin
                    if (sb.size() == 0) begin
                        chk("out_vld_unexpected", {31'd0, bus.out_vld}, 32'd0);
                    end else begin
                        p = sb.pop_front();
                        chk("out_lft", {8'd0, bus.out_lft}, {8'd0, p.l});
                        chk("out_rght", {8'd0, bus.out_rght}, {8'd0, p.r});
                        chk("out_latency", cyc - adv_cyc, 2);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic pulse_vld(input logic [23:0] l, input logic [23:0] r);
        @(posedge clk);
        #1;
        bus.vld = 1'b1;
        bus.lft_chnnl = l;
        bus.rght_chnnl = r;
    endtask

    task automatic drop_vld();
        @(posedge clk);
        #1;
        bus.vld = 1'b0;
    endtask

    task automatic drain(input string name, input int max);
        for (int i = 0; i < max && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk(name, sb.size(), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_eng_strt"}, {31'd0, bus.eng_strt}, 32'd0);
        chk({tag, "_eng_chnl"}, {31'd0, bus.eng_chnl}, 32'd0);
        chk({tag, "_eng_smpl"}, {8'd0, bus.eng_smpl}, 32'd0);
        chk({tag, "_out_vld"}, {31'd0, bus.out_vld}, 32'd0);
        chk({tag, "_out_lft"}, {8'd0, bus.out_lft}, 32'd0);
        chk({tag, "_out_rght"}, {8'd0, bus.out_rght}, 32'd0);
        chk({tag, "_ovrn"}, {31'd0, bus.ovrn}, 32'd0);
        chk({tag, "_tmo"}, {31'd0, bus.tmo}, 32'd0);
    endtask

    initial begin
        int n;
        vt[0] = '{l: 24'h123456, r: 24'hFEDCBA, dly: 5,  silent: 1'b0, el: 24'h123457, er: 24'hFEDCBB, ntmo: 0};
        vt[1] = '{l: 24'h7FFFFF, r: 24'h800000, dly: 3,  silent: 1'b0, el: 24'h800000, er: 24'h800001, ntmo: 0};
        vt[2] = '{l: 24'hFFFFFF, r: 24'h000000, dly: 1,  silent: 1'b0, el: 24'h000000, er: 24'h000001, ntmo: 0};
        vt[3] = '{l: 24'h0AAAAA, r: 24'h155555, dly: 5,  silent: 1'b1, el: 24'h0AAAAA, er: 24'h155555, ntmo: 2};
        vt[4] = '{l: 24'h000001, r: 24'hFFFFFE, dly: 16, silent: 1'b0, el: 24'h000002, er: 24'hFFFFFF, ntmo: 0};
        vt[5] = '{l: 24'h3C3C3C, r: 24'hC3C3C3, dly: 15, silent: 1'b0, el: 24'h3C3C3D, er: 24'hC3C3C4, ntmo: 0};

        bus.vld = 1'b0;
        bus.lft_chnnl = '0;
        bus.rght_chnnl = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            eng_dly = vt[i].dly;
            eng_silent = vt[i].silent;
            tmo_seen = 0;
            sb.push_back('{l: vt[i].el, r: vt[i].er});
            pulse_vld(vt[i].l, vt[i].r);
            n = cyc;
            drop_vld();
            @(posedge clk);
            #1;
            chk("strt_latency_cyc", cyc - n, 2);
            chk("strt_latency", {31'd0, bus.eng_strt}, 32'd1);
            drain("vec_drain", 200);
            chk("vec_tmo_count", tmo_seen, vt[i].ntmo);
        end
        eng_silent = 1'b0;

        // second pair buffered while left is in flight, third pair dropped
        eng_dly = 5;
        ovrn_seen = 0;
        sb.push_back('{l: 24'h111112, r: 24'h222223});
        sb.push_back('{l: 24'h333334, r: 24'h444445});
        pulse_vld(24'h111111, 24'h222222);
        n = cyc;
        drop_vld();
        @(posedge clk);
        pulse_vld(24'h333333, 24'h444444);
        pulse_vld(24'h555555, 24'h666666);
        drop_vld();
        drain("ovrn_drain", 300);
        chk("ovrn_count", ovrn_seen, 1);
        chk("ovrn_cycle", ovrn_cyc - n, 5);

        // vld coincident with the FSM consuming the buffer is accepted
        ovrn_seen = 0;
        sb.push_back('{l: 24'hABCDF0, r: 24'h0FEDCC});
        sb.push_back('{l: 24'h000100, r: 24'h800100});
        pulse_vld(24'hABCDEF, 24'h0FEDCB);
        pulse_vld(24'h0000FF, 24'h8000FF);
        drop_vld();
        drain("consume_drain", 300);
        chk("consume_no_ovrn", ovrn_seen, 0);

        // stray eng_done while idle must be ignored
        stray_req = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("stray_eng_strt", {31'd0, bus.eng_strt}, 32'd0);
        chk("stray_out_lft", {8'd0, bus.out_lft}, 32'h000100);
        chk("stray_out_rght", {8'd0, bus.out_rght}, 32'h800100);

        // reset while the right channel is in flight
        eng_dly = 5;
        sb.push_back('{l: 24'h0F0F10, r: 24'hF0F0F1});
        pulse_vld(24'h0F0F0F, 24'hF0F0F0);
        drop_vld();
        for (int i = 0; i < 60 && !(bus.eng_strt && bus.eng_chnl); i++) begin
            @(posedge clk);
            #1;
        end
        chk("reach_rght", {31'd0, bus.eng_chnl}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        sb.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        sb.push_back('{l: 24'h246802, r: 24'h13579C});
        pulse_vld(24'h246801, 24'h13579B);
        drop_vld();
        drain("postrst_drain", 200);

`ifdef CHNL_SEQ_OVRN_CNT_EN
        sb_on = 1'b0;
        eng_dly = 200;
        for (int i = 0; i < 300; i++) pulse_vld(24'($urandom), 24'($urandom));
        drop_vld();
        repeat (2) @(posedge clk);
        #1;
        chk("ovrn_cnt_sat", {24'd0, ovrn_cnt}, 32'd255);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ovrn_cnt_rst", {24'd0, ovrn_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/chnl_seq.md
CHNL_SEQ -- requirements
Module: chnl_seq

Interface
REQ-001 Parameter TMO_CYC, default 1023, engine-response timeout in clk cycles (1..1023).
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 vld  input  1  one-cycle pulse; left/right sample pair valid from I2S receiver.
REQ-005 lft_chnnl  input  24  left sample, signed two's complement, valid with vld.
REQ-006 rght_chnnl  input  24  right sample, signed, valid with vld.
REQ-007 eng_strt  output  1  one-cycle request to the shared filter engine.
REQ-008 eng_chnl  output  1  channel being processed: 0 = left, 1 = right; stable from eng_strt until done or timeout.
REQ-009 eng_smpl  output  24  sample presented to the engine; stable with eng_chnl.
REQ-010 eng_done  input  1  one-cycle engine completion pulse.
REQ-011 eng_rslt  input  24  engine result, valid with eng_done.
REQ-012 out_vld  output  1  one-cycle pulse; processed pair valid.
REQ-013 out_lft / out_rght  output  24 each  processed samples, held until the next out_vld.
REQ-014 ovrn  output  1  one-cycle pulse; input pair dropped.
REQ-015 tmo  output  1  one-cycle pulse; engine timed out and the sample was bypassed.

Function
REQ-016 One-deep holding buffer (hold_l, hold_r, pend); vld with pend=0 captures both samples and sets pend.
REQ-017 vld with pend=1, not cleared that cycle -> pair discarded, held data unchanged, ovrn pulses the next cycle.
REQ-018 vld in the same cycle the FSM consumes pend -> new pair captured, pend remains 1, no ovrn.
REQ-019 FSM states IDLE, LFT, RGHT, DONE; encoding is the shared enum.
REQ-020 IDLE & pend -> copy hold to working regs, clear pend, go LFT; eng_strt=1, eng_chnl=0, eng_smpl=left on the next cycle.
REQ-021 LFT: eng_done -> latch eng_rslt as left result, go RGHT; eng_strt=1, eng_chnl=1, eng_smpl=right on the next cycle.
REQ-022 RGHT: eng_done -> latch right result, go DONE; DONE asserts out_vld for one cycle and returns to IDLE.
REQ-023 Latency with an idle FSM: eng_strt (left) in cycle N+2 for vld in cycle N; out_vld in cycle M+2 for the right eng_done in cycle M.
REQ-024 Timeout counter clears on every eng_strt and increments in LFT/RGHT; at count TMO_CYC with no eng_done, the working input sample is substituted as the result, tmo pulses, and the FSM advances as if done.
REQ-025 eng_done and timeout in the same cycle -> eng_done wins, no tmo.
REQ-026 eng_done in IDLE or DONE is ignored; no state or output change.
REQ-027 Results are passed through bit-exact; no saturation or width change.

Reset
REQ-028 rst_n low -> state IDLE, pend=0, timeout counter 0; eng_strt, out_vld, ovrn, tmo = 0; eng_chnl=0; eng_smpl, out_lft, out_rght = 0.
REQ-029 Reset mid-operation abandons the in-flight pair; the first out_vld after reset is produced only from a vld received after reset.

Configuration
REQ-030 Macro CHNL_SEQ_OVRN_CNT_EN defined -> extra output ovrn_cnt (8-bit) counts ovrn pulses, saturates at 255, and is cleared only by reset.
REQ-031 Macro undefined -> port ovrn_cnt and its logic are absent; all other behaviour is identical.

Structure
REQ-032 Shared package eq_pkg holds the state enum, the constant SMPL_W=24, and the channel-select encoding constants.
REQ-033 The timeout counter is a sub-module eng_wdog (inputs clr, en; output expired) parameterised by TMO_CYC.

Verification
REQ-034 vld with L=24'h123456, R=24'hFEDCBA; engine returns input+1 after 5 cycles -> out_vld with out_lft=24'h123457, out_rght=24'hFEDCBB.
REQ-035 Second vld while LFT is pending and pend=1 -> ovrn pulses once, the first pair completes unchanged, and the dropped pair never appears.
REQ-036 Engine silent with TMO_CYC=16 -> tmo pulses 16 cycles after each eng_strt; out_lft/out_rght equal the raw inputs.
REQ-037 eng_done and expiry in the same cycle -> tmo stays 0 and eng_rslt is used.
REQ-038 rst_n asserted during RGHT -> all outputs are 0 immediately; a fresh vld then completes normally.
REQ-039 With CHNL_SEQ_OVRN_CNT_EN defined, 300 forced overruns -> ovrn_cnt=255.
